commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 151 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures register writebacks and data-memory accesses,
// up to two entries per cycle, with sequence numbering and drop accounting.

module ctb_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module commit_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [8:0]                 addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [8:0]                 out_idx,
  output logic [DATA_W-1:0]          out_data,
  output logic [15:0]                out_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int ENT_W = 2 + 9 + DATA_W + 16;

  typedef struct packed {
    logic [1:0]        kind;
    logic [8:0]        idx;
    logic [DATA_W-1:0] data;
    logic [15:0]       seq;
  } ent_t;

  logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [LW-1:0] level_q;
  logic [15:0]   seq_q;
  logic          ovf_q;
  logic [7:0]    drop_q;

  logic          reg_ev, mem_ev, pop;
  logic [1:0]    n_ev, n_push, n_drop;
  logic [LW:0]   cap;
  logic [8:0]    drop_sum;
  ent_t          reg_ent, mem_ent, ent0, ent1, head;

  logic [DEPTH-1:0]            slot_we;
  logic [DEPTH-1:0][ENT_W-1:0] slot_d;
  logic [DEPTH-1:0][ENT_W-1:0] slot_q;

  always_comb begin
    reg_ev = en & reg_write_sig & (reg_num != 5'd0);
    mem_ev = en & (wr | rd);

    reg_ent.kind = 2'b01;
    reg_ent.idx  = {4'b0, reg_num};
    reg_ent.data = reg_data;
    reg_ent.seq  = seq_q;

    // A simultaneous reg event is older, so the mem event takes the next seq.
    mem_ent.kind = wr ? 2'b10 : 2'b11;
    mem_ent.idx  = addr;
    mem_ent.data = wr ? wr_data : rd_data;
    mem_ent.seq  = seq_q + {15'b0, reg_ev};

    ent0 = reg_ev ? reg_ent : mem_ent;
    ent1 = mem_ent;

    n_ev = {1'b0, reg_ev} + {1'b0, mem_ev};
    pop  = (level_q != '0) & out_ready;
    cap  = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);

    if (cap >= (LW+1)'(n_ev)) n_push = n_ev;
    else                      n_push = cap[1:0];
    n_drop   = n_ev - n_push;
    drop_sum = {1'b0, drop_q} + 9'(n_drop);
    wr_ptr1  = wr_ptr + 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    always_comb begin
      slot_we[i] = ((n_push != 2'd0) && (wr_ptr  == PW'(i))) ||
                   ((n_push == 2'd2) && (wr_ptr1 == PW'(i)));
      slot_d[i]  = (wr_ptr == PW'(i)) ? ent0 : ent1;
    end

    ctb_slot #(.W(ENT_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (slot_we[i]),
      .d     (slot_d[i]),
      .q     (slot_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop);
      wr_ptr  <= wr_ptr + PW'(n_push);
      level_q <= level_q + LW'(n_push) - LW'(pop);
      seq_q   <= seq_q + 16'(n_ev);
      // A drop in the same cycle as a clear restarts the count from this drop.
      if (n_drop != 2'd0) begin
        ovf_q  <= 1'b1;
        drop_q <= clr_ovf ? 8'(n_drop) : (drop_sum[8] ? 8'hFF : drop_sum[7:0]);
      end else if (clr_ovf) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  always_comb begin
    head      = ent_t'(slot_q[rd_ptr]);
    out_valid = (level_q != '0);
    out_kind  = out_valid ? head.kind : 2'b00;
    out_idx   = out_valid ? head.idx  : 9'd0;
    out_data  = out_valid ? head.data : '0;
    out_seq   = out_valid ? head.seq  : 16'd0;
    level     = level_q;
    overflow  = ovf_q;
    drop_cnt  = drop_q;
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed checks of commit_trace_buffer against a queue model.

module tb_commit_trace_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic [1:0]  kind;
    logic [8:0]  idx;
    logic [31:0] data;
    logic [15:0] seq;
  } ent_t;

  logic clk = 0, reset = 0, en = 0, reg_write_sig = 0, wr = 0, rd = 0;
  logic out_ready = 0, clr_ovf = 0;
  logic [4:0]  reg_num = 0;
  logic [8:0]  addr = 0;
  logic [31:0] reg_data = 0, wr_data = 0, rd_data = 0;
  logic        out_valid, overflow;
  logic [1:0]  out_kind;
  logic [8:0]  out_idx;
  logic [31:0] out_data;
  logic [15:0] out_seq;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int nvec = 0, nerr = 0;

  ent_t        m_q[$];
  logic [15:0] m_seq;
  bit          m_ovf;
  int          m_dcnt;

  commit_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_idx(out_idx),
    .out_data(out_data), .out_seq(out_seq), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_q.delete();
    m_seq  = 0;
    m_ovf  = 0;
    m_dcnt = 0;
  endtask

  // Pop happens first, then events enter in order while room remains.
  task automatic model_step();
    ent_t ev[$];
    int   drops = 0;
    if (en && reg_write_sig && reg_num != 0) begin
      ev.push_back({2'b01, {4'b0, reg_num}, reg_data, m_seq});
      m_seq++;
    end
    if (en && (wr || rd)) begin
      ev.push_back({wr ? 2'b10 : 2'b11, addr, wr ? wr_data : rd_data, m_seq});
      m_seq++;
    end
    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
    foreach (ev[i]) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev[i]);
      else drops++;
    end
    if (drops > 0) begin
      m_ovf  = 1;
      m_dcnt = clr_ovf ? drops : ((m_dcnt + drops > 255) ? 255 : m_dcnt + drops);
    end else if (clr_ovf) begin
      m_ovf  = 0;
      m_dcnt = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1; reg_write_sig = 0; reg_num = 0; wr = 0; rd = 0; clr_ovf = 0;
  endtask

  task automatic reg_event(input int n);
    reg_write_sig = 1;
    reg_num  = 5'(1 + (n % 31));
    reg_data = $urandom;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 0;
    reset = 0;
    @(negedge clk);
    model_clear();
    reset = 1;
  endtask

  task automatic test_reset();
    #1;
    nvec++;
    if ({out_valid, level, overflow, drop_cnt} !== '0) begin
      nerr++; $display("FAIL reset_status: got v=%b lvl=%0d ovf=%b dc=%0d want all 0", out_valid, level, overflow, drop_cnt);
    end
    nvec++;
    if ({out_kind, out_idx, out_data, out_seq} !== '0) begin
      nerr++; $display("FAIL reset_head: got %h want 0", {out_kind, out_idx, out_data, out_seq});
    end
    @(negedge clk);
    model_clear();
    reset = 1;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1;
    reg_write_sig = 1; reg_num = 5; reg_data = 32'hDEADBEEF;
    tick();
    idle();
    nvec++;
    if ({out_valid, out_kind, out_idx, out_data, out_seq} !== {1'b1, 2'b01, 9'd5, 32'hDEADBEEF, 16'd0}) begin
      nerr++; $display("FAIL single: got v=%b k=%b i=%h d=%h s=%0d want 1 01 005 deadbeef 0", out_valid, out_kind, out_idx, out_data, out_seq);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL single_pop: got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_dual();
    do_reset();
    reg_write_sig = 1; reg_num = 3; reg_data = 32'h11;
    wr = 1; addr = 9'h40; wr_data = 32'h22;
    tick();
    idle();
    nvec++;
    if ({out_valid, out_kind, out_idx, out_data, out_seq, level} !== {1'b1, 2'b01, 9'd3, 32'h11, 16'd0, 4'd2}) begin
      nerr++; $display("FAIL dual_first: got k=%b i=%h d=%h s=%0d lvl=%0d want 01 003 11 0 2", out_kind, out_idx, out_data, out_seq, level);
    end
    out_ready = 1;
    tick();
    nvec++;
    if ({out_valid, out_kind, out_idx, out_data, out_seq} !== {1'b1, 2'b10, 9'h40, 32'h22, 16'd1}) begin
      nerr++; $display("FAIL dual_second: got k=%b i=%h d=%h s=%0d want 10 040 22 1", out_kind, out_idx, out_data, out_seq);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL dual_empty: got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_x0_conflict();
    do_reset();
    reg_write_sig = 1; reg_num = 0; reg_data = 32'h55;
    tick();
    idle();
    nvec++;
    if ({out_valid, level} !== 5'd0) begin
      nerr++; $display("FAIL x0_write: got v=%b lvl=%0d want 0 0", out_valid, level);
    end
    wr = 1; rd = 1; addr = 9'h1A5; wr_data = 32'hAAAA0001; rd_data = 32'hBBBB0002;
    tick();
    idle();
    nvec++;
    if ({level, out_kind, out_idx, out_data, out_seq} !== {4'd1, 2'b10, 9'h1A5, 32'hAAAA0001, 16'd0}) begin
      nerr++; $display("FAIL wr_rd_conflict: got lvl=%0d k=%b i=%h d=%h s=%0d want 1 10 1a5 aaaa0001 0", level, out_kind, out_idx, out_data, out_seq);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      reg_event(i);
      tick();
    end
    reg_event(7);
    rd = 1; addr = 9'h10; rd_data = 32'h77;
    tick();
    idle();
    nvec++;
    if ({level, overflow, drop_cnt} !== {4'd8, 1'b1, 8'd1}) begin
      nerr++; $display("FAIL overflow_fill: got lvl=%0d ovf=%b dc=%0d want 8 1 1", level, overflow, drop_cnt);
    end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (out_seq !== 16'(i)) begin
        nerr++; $display("FAIL drain_seq: got %0d want %0d", out_seq, i);
      end
      tick();
    end
    out_ready = 0;
    reg_event(3);
    tick();
    idle();
    nvec++;
    if ({out_valid, out_seq} !== {1'b1, 16'd9}) begin
      nerr++; $display("FAIL seq_gap: got v=%b s=%0d want 1 9", out_valid, out_seq);
    end
  endtask

  task automatic test_full_pop_clr();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      reg_event(i);
      tick();
    end
    out_ready = 1;
    reg_event(20);
    tick();
    idle();
    out_ready = 0;
    nvec++;
    if ({level, overflow, drop_cnt, out_seq} !== {4'd8, 1'b0, 8'd0, 16'd1}) begin
      nerr++; $display("FAIL full_pop: got lvl=%0d ovf=%b dc=%0d s=%0d want 8 0 0 1", level, overflow, drop_cnt, out_seq);
    end
    reg_event(4); wr = 1; clr_ovf = 1;
    tick();
    idle();
    nvec++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd2}) begin
      nerr++; $display("FAIL clr_vs_drop: got ovf=%b dc=%0d want 1 2", overflow, drop_cnt);
    end
    clr_ovf = 1;
    tick();
    idle();
    nvec++;
    if ({overflow, drop_cnt} !== {1'b0, 8'd0}) begin
      nerr++; $display("FAIL clr: got ovf=%b dc=%0d want 0 0", overflow, drop_cnt);
    end
    for (int i = 0; i < 130; i++) begin
      reg_event(i); rd = 1;
      tick();
    end
    idle();
    nvec++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd255}) begin
      nerr++; $display("FAIL drop_sat: got ovf=%b dc=%0d want 1 255", overflow, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      reg_event(i);
      tick();
    end
    idle();
    nvec++;
    if (level !== 4'd5) begin
      nerr++; $display("FAIL mid_fill: got lvl=%0d want 5", level);
    end
    #2 reset = 0;
    #1;
    nvec++;
    if ({out_valid, level, out_seq} !== 21'd0) begin
      nerr++; $display("FAIL mid_reset: got v=%b lvl=%0d s=%0d want 0 0 0", out_valid, level, out_seq);
    end
    @(negedge clk);
    model_clear();
    reset = 1;
    reg_event(9);
    tick();
    idle();
    nvec++;
    if ({out_valid, level, out_seq} !== {1'b1, 4'd1, 16'd0}) begin
      nerr++; $display("FAIL mid_first_seq: got v=%b lvl=%0d s=%0d want 1 1 0", out_valid, level, out_seq);
    end
  endtask

  task automatic test_random();
    ent_t exp;
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      en            = ($urandom_range(0, 7) != 0);
      reg_write_sig = $urandom_range(0, 1);
      reg_num       = 5'($urandom);
      reg_data      = $urandom;
      wr            = ($urandom_range(0, 2) == 0);
      rd            = ($urandom_range(0, 2) == 0);
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      clr_ovf       = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 3 : 8));
      tick();
      exp = (m_q.size() > 0) ? m_q[0] : '0;
      nvec++;
      if ({out_valid, out_kind, out_idx, out_data, out_seq} !== {m_q.size() > 0, exp}) begin
        nerr++; $display("FAIL rand_head c=%0d: got %b %h want %b %h", c, out_valid,
                         {out_kind, out_idx, out_data, out_seq}, m_q.size() > 0, exp);
      end
      nvec++;
      if ({level, overflow, drop_cnt} !== {4'(m_q.size()), m_ovf, 8'(m_dcnt)}) begin
        nerr++; $display("FAIL rand_status c=%0d: got lvl=%0d ovf=%b dc=%0d want %0d %b %0d", c,
                         level, overflow, drop_cnt, m_q.size(), m_ovf, m_dcnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_x0_conflict();
    test_overflow();
    test_full_pop_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
